// File: rtl/aemb2_pipectl.sv
// AEMB2 pipeline control: post-reset delay, thread issue rotation,
// interrupt pending/priority, hardware-break latch and stall counting.
module aemb2_pipectl #(
    parameter int NTHR   = 2,
    parameter int TW     = 1,
    parameter int NINT   = 4,
    parameter int IW     = 2,
    parameter int RSTDLY = 2
) (
    input  logic            sys_clk_i,
    input  logic            grst,
    input  logic            sys_ena_i,
    input  logic            ich_fb,
    input  logic            xwb_fb,
    input  logic            dwb_fb,
    input  logic [NINT-1:0] irq_i,
    input  logic [NINT-1:0] irq_msk_i,
    input  logic            irq_ack_i,
    input  logic            sys_brk_i,
    input  logic [NTHR-1:0] msr_ie_i,
    input  logic [NTHR-1:0] msr_bip_i,
    output logic            rdy_o,
    output logic            ena_o,
    output logic [TW-1:0]   thr_o,
    output logic [1:0]      brk_if_o,
    output logic [IW-1:0]   irq_vec_o,
    output logic [15:0]     stl_cnt_o
);

    logic [3:0]      dly;
    logic [NINT-1:0] pend;
    logic [NINT-1:0] pend_en;
    logic [NINT-1:0] clr;
    logic            irq_any;
    logic            brkl;
    logic            ie_cur;
    logic            bip_cur;

    assign rdy_o   = (dly == 4'(RSTDLY));
    assign ena_o   = rdy_o & ich_fb & xwb_fb & dwb_fb & sys_ena_i;
    assign pend_en = pend & irq_msk_i;
    assign irq_any = |pend_en;
    assign ie_cur  = msr_ie_i[thr_o];
    assign bip_cur = msr_bip_i[thr_o];

    // lowest-numbered pending, enabled source wins
    always_comb begin
        irq_vec_o = '0;
        for (int i = NINT - 1; i >= 0; i--) begin
            if (pend_en[i]) irq_vec_o = IW'(i);
        end
    end

    // an ack with nothing pending and enabled must not touch pend[0]
    always_comb begin
        clr = '0;
        if (irq_ack_i && irq_any) clr[irq_vec_o] = 1'b1;
    end

    always_ff @(posedge sys_clk_i) begin
        if (grst) begin
            dly <= 4'd0;
        end else if (dly < 4'(RSTDLY)) begin
            dly <= dly + 4'd1;
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (grst) begin
            thr_o <= '0;
        end else if (ena_o) begin
            if (NTHR == 1 || thr_o == TW'(NTHR - 1)) thr_o <= '0;
            else thr_o <= thr_o + TW'(1);
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (grst) begin
            pend <= '0;
            brkl <= 1'b0;
        end else begin
            pend <= (pend & ~clr) | irq_i;
            brkl <= (brkl | sys_brk_i) & ~(ena_o & brk_if_o[1]);
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (grst) begin
            brk_if_o <= 2'b00;
        end else if (ena_o) begin
            brk_if_o[0] <= irq_any & ie_cur & ~bip_cur;
            brk_if_o[1] <= brkl & ~bip_cur;
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (grst) begin
            stl_cnt_o <= 16'd0;
        end else if (rdy_o && !ena_o && !(&stl_cnt_o)) begin
            stl_cnt_o <= stl_cnt_o + 16'd1;
        end
    end

endmodule

// File: doc/aemb2_pipectl.md
AEMB2_PIPECTL -- requirements
Module: aemb2_pipectl

Interface
REQ-001 SHALL have parameter NTHR, default 2, number of hardware threads; legal values 1, 2, 4.
REQ-002 SHALL have parameter TW, default 1, thread-id width: max(1, log2(NTHR)).
REQ-003 SHALL have parameter NINT, default 4, number of interrupt sources; legal values 1..16.
REQ-004 SHALL have parameter IW, default 2, interrupt-vector width: max(1, ceil(log2(NINT))).
REQ-005 SHALL have parameter RSTDLY, default 2, number of post-reset delay cycles; legal values 1..15.
REQ-006 sys_clk_i  in  1  system clock; every flop is clocked on its rising edge.
REQ-007 grst  in  1  reset, synchronous, active-high; clock sys_clk_i.
REQ-008 sys_ena_i  in  1  global run enable.
REQ-009 ich_fb, xwb_fb, dwb_fb  in  1 each  feedback ready from the instruction cache, XSL bus and data bus respectively.
REQ-010 irq_i  in  NINT  level interrupt requests.
REQ-011 irq_msk_i  in  NINT  per-source enable mask; 1 = enabled.
REQ-012 irq_ack_i  in  1  single-cycle pulse: the interrupt at irq_vec_o has been taken.
REQ-013 sys_brk_i  in  1  hardware break request, level.
REQ-014 msr_ie_i, msr_bip_i  in  NTHR each  per-thread MSR interrupt-enable and break-in-progress bits.
REQ-015 rdy_o  out  1  reset-delay complete.
REQ-016 ena_o  out  1  pipeline advance enable.
REQ-017 thr_o  out  TW  thread currently issuing.
REQ-018 brk_if_o  out  2  [0] interrupt break, [1] hardware break, for the thread in thr_o.
REQ-019 irq_vec_o  out  IW  index of the lowest-numbered pending, enabled source.
REQ-020 stl_cnt_o  out  16  saturating stall-cycle count.

Function
REQ-021 Reset delay: dly counter increments once per cycle, starting from 0 after grst falls, while below RSTDLY. rdy_o SHALL be 1 from the cycle dly==RSTDLY, i.e. RSTDLY cycles after grst deasserts.
REQ-022 ena_o SHALL be combinational: rdy_o & ich_fb & xwb_fb & dwb_fb & sys_ena_i.
REQ-023 thr_o SHALL advance (thr_o+1) mod NTHR on each cycle with ena_o=1 and hold otherwise; thr_o SHALL be 0 whenever NTHR=1 or rdy_o=0.
REQ-024 Pending latch: per source, pend[i] <= (pend[i] & ~clr[i]) | irq_i[i], where clr[i] = irq_ack_i & (irq_vec_o==i). A set in the same cycle as a clear SHALL leave pend set.
REQ-025 irq_vec_o SHALL be combinational: lowest i with pend[i] & irq_msk_i[i]; 0 when none.
REQ-026 irq_ack_i when no source is pending and enabled SHALL change no state.
REQ-027 Break latch: brkl <= (brkl | sys_brk_i) & ~(ena_o & brk_if_o[1]), so a break is held until it has been presented for one enabled cycle.
REQ-028 brk_if_o SHALL be registered and update only on cycles with ena_o=1; on all other cycles it holds.
REQ-029 On an update: brk_if_o[0] <= |(pend & irq_msk_i) & msr_ie_i[thr_o] & ~msr_bip_i[thr_o]; brk_if_o[1] <= brkl & ~msr_bip_i[thr_o], where thr_o is the pre-advance value.
REQ-030 stl_cnt_o SHALL increment by 1 on each cycle with rdy_o=1 and ena_o=0, and saturate at 16'hFFFF with no wrap.
REQ-031 msr_ie_i and msr_bip_i SHALL be sampled only on ena_o cycles; there is no other path from them to state.

Reset
REQ-032 While grst=1, SHALL hold: dly=0, rdy_o=0, thr_o=0, pend=0, brkl=0, brk_if_o=2'b00, stl_cnt_o=0. ena_o is consequently 0 and irq_vec_o is 0.
REQ-033 Asserting grst mid-operation SHALL discard all pending interrupts, the held break and the stall count, and SHALL restart the RSTDLY delay.

Verification
REQ-034 Release grst with RSTDLY=2 and all fb inputs =1 -> rdy_o=0 for cycles 0-1, then rdy_o=1 and ena_o=1; thr_o sequence 0,1,0,1 (NTHR=2).
REQ-035 Pulse irq_i=4'b1010 for one cycle, irq_msk_i=4'hF -> irq_vec_o=1; irq_ack_i -> irq_vec_o=3; second irq_ack_i -> pend=0, irq_vec_o=0.
REQ-036 pend[2]=1, msr_ie_i=2'b01, msr_bip_i=0 -> brk_if_o[0]=1 only after an enabled cycle issuing thread 0, and 0 after one issuing thread 1.
REQ-037 Hold dwb_fb=0 for 5 cycles after rdy_o -> ena_o=0, thr_o and brk_if_o hold, stl_cnt_o=5; preload the count near 16'hFFFF and continue stalling -> stays at 16'hFFFF.
REQ-038 irq_i[0] asserted in the same cycle as irq_ack_i with irq_vec_o=0 -> pend[0] remains 1.
REQ-039 Assert grst for one cycle with pend!=0 and stl_cnt_o!=0 -> all outputs return to their REQ-032 values, and rdy_o re-asserts after RSTDLY cycles.
